// File: rtl/mod_mul_pkg.sv
// Shared constants for the Montgomery multiplier and its arbiter front end.
// The field is the BLS12-381 scalar field; R = 2^256.
package mod_mul_pkg;

    localparam int unsigned DATA_WIDTH = 255;

    typedef logic [DATA_WIDTH-1:0] operand_t;

    // Field prime p.
    localparam operand_t MODULUS =
        255'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;

    // R mod p: multiplying a by this in the Montgomery domain returns a.
    localparam operand_t MOD_COMPENSATION =
        255'h1824b159acc5056f998c4fefecbc4ff55884b7fa0003480200000001fffffffe;

    // -p^-1 mod 2^64, the per-digit reduction factor.
    localparam logic [63:0] M_INVERSE = 64'hfffffffeffffffff;

    // Ceiling log2 with a floor of 1 so single-entry structures still get a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_mul_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to the
// bottom of the vector. Purely combinational.
module mod_mul_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Two passes: upper segment [ptr, NUM_REQ) first, then the wrapped [0, ptr).
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_o && req_i[k] && (k >= 32'(ptr_i))) begin
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
                any_o    = 1'b1;
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_o && req_i[k] && (k < 32'(ptr_i))) begin
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_mul_arbiter.sv
// Shares one in-order Montgomery multiplier among NUM_REQ requesters.
// Grants round-robin, remembers each winner in a tag FIFO, and steers each
// returning result to the requester at the FIFO head.
module mod_mul_arbiter #(
    parameter int unsigned DATA_WIDTH = mod_mul_pkg::DATA_WIDTH,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TAG_DEPTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_op2_i,
    output logic [NUM_REQ-1:0]              res_valid_o,
    input  logic [NUM_REQ-1:0]              res_ready_i,
    output logic [DATA_WIDTH-1:0]           res_o,
    output logic                            mul_op_valid_o,
    input  logic                            mul_op_ready_i,
    output logic [DATA_WIDTH-1:0]           mul_op1_o,
    output logic [DATA_WIDTH-1:0]           mul_op2_o,
    input  logic                            mul_res_valid_i,
    output logic                            mul_res_ready_o,
    input  logic [DATA_WIDTH-1:0]           mul_res_i,
    output logic                            busy_o,
    output logic                            err_orphan_o,
    output logic [31:0]                     op_count_o
);

    import mod_mul_pkg::*;

    localparam int unsigned TAG_W = clog2(NUM_REQ);
    localparam int unsigned PTR_W = clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = clog2(TAG_DEPTH + 1);

    logic [TAG_W-1:0]   r_ptr;
    logic [TAG_W-1:0]   r_tags [TAG_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_op_count;
    logic               r_err_orphan;

    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [TAG_W-1:0]   w_gnt_idx;
    logic               w_any;
    logic [TAG_W-1:0]   w_ptr_next;
    logic               w_tag_empty;
    logic               w_tag_full;
    logic [TAG_W-1:0]   w_head;
    logic               w_head_ready;
    logic               w_res_vld;
    logic               w_push;
    logic               w_pop;
    logic               w_orphan;

    mod_mul_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (TAG_W)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (r_ptr),
        .gnt_o   (w_gnt_oh),
        .idx_o   (w_gnt_idx),
        .any_o   (w_any)
    );

    // Full is judged before any same-cycle pop, so a push while full waits a cycle.
    assign w_tag_empty = (r_count == '0);
    assign w_tag_full  = (r_count == CNT_W'(TAG_DEPTH));
    assign w_head      = r_tags[r_rd_ptr];
    assign w_ptr_next  = (w_gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Issue side: valid never looks at mul_op_ready_i; handshake outputs held low in reset.
    assign mul_op_valid_o = !rst && w_any && !w_tag_full;
    assign w_push         = mul_op_valid_o && mul_op_ready_i;
    assign req_ready_o    = w_push ? w_gnt_oh : '0;

    // Forward the winner's operands; zero when nobody is requesting.
    always_comb begin
        mul_op1_o = '0;
        mul_op2_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_oh[k]) begin
                mul_op1_o = req_op1_i[k*DATA_WIDTH +: DATA_WIDTH];
                mul_op2_o = req_op2_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Return side: decode the FIFO head into a one-hot valid and pick its ready.
    always_comb begin
        res_valid_o  = '0;
        w_head_ready = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (w_head == TAG_W'(k)) begin
                res_valid_o[k] = w_res_vld;
                w_head_ready   = res_ready_i[k];
            end
        end
    end

    // A result with no outstanding tag is an orphan: drain it and flag the error.
    assign w_res_vld       = !rst && mul_res_valid_i && !w_tag_empty;
    assign w_orphan        = !rst && mul_res_valid_i && w_tag_empty;
    assign mul_res_ready_o = !rst && (w_tag_empty ? mul_res_valid_i : w_head_ready);
    assign w_pop           = w_res_vld && w_head_ready;
    assign res_o           = mul_res_i;

    assign busy_o       = !rst && !w_tag_empty;
    assign err_orphan_o = r_err_orphan;
    assign op_count_o   = r_op_count;

    // Control state: rr pointer, FIFO pointers/count, op counter, sticky orphan flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_op_count   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_ptr      <= w_ptr_next;
                r_wr_ptr   <= (r_wr_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                r_op_count <= r_op_count + 32'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= w_gnt_idx;
        end
    end

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Bench for mod_mul_arbiter with a behavioural in-order multiplier
// (3-cycle latency, returns op1 when op2 is R mod p).
module tb_mod_mul_arbiter;

    localparam int unsigned DW = mod_mul_pkg::DATA_WIDTH;
    localparam int unsigned NR = 4;
    localparam logic [DW-1:0] MC = mod_mul_pkg::MOD_COMPENSATION;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid_i = '0;
    logic [NR-1:0]      req_ready_o;
    logic [NR*DW-1:0]   req_op1_i = '0;
    logic [NR*DW-1:0]   req_op2_i = '0;
    logic [NR-1:0]      res_valid_o;
    logic [NR-1:0]      res_ready_i = '0;
    logic [DW-1:0]      res_o;
    logic               mul_op_valid_o;
    logic               mul_op_ready_i = 1'b0;
    logic [DW-1:0]      mul_op1_o;
    logic [DW-1:0]      mul_op2_o;
    logic               mul_res_valid_i;
    logic               mul_res_ready_o;
    logic [DW-1:0]      mul_res_i;
    logic               busy_o;
    logic               err_orphan_o;
    logic [31:0]        op_count_o;

    logic               force_orphan = 1'b0;
    logic               hold = 1'b0;
    logic [NR-1:0]      last_rdy = '0;

    int checks = 0;
    int errs   = 0;

    logic [NR-1:0] gnt_q [$];
    logic [NR-1:0] rb_q  [$];
    logic [DW-1:0] rv_q  [$];

    mod_mul_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .TAG_DEPTH  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op1_i       (req_op1_i),
        .req_op2_i       (req_op2_i),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready_i),
        .res_o           (res_o),
        .mul_op_valid_o  (mul_op_valid_o),
        .mul_op_ready_i  (mul_op_ready_i),
        .mul_op1_o       (mul_op1_o),
        .mul_op2_o       (mul_op2_o),
        .mul_res_valid_i (mul_res_valid_i),
        .mul_res_ready_o (mul_res_ready_o),
        .mul_res_i       (mul_res_i),
        .busy_o          (busy_o),
        .err_orphan_o    (err_orphan_o),
        .op_count_o      (op_count_o)
    );

    always #5 clk = ~clk;

    // Multiplier model: in-order queue, each entry visible 3 cycles after accept.
    logic [DW-1:0] mq_data [$];
    int            mq_due  [$];
    int            cyc = 0;
    logic          mdl_vld = 1'b0;
    logic [DW-1:0] mdl_res = '0;

    assign mul_res_valid_i = mdl_vld | force_orphan;
    assign mul_res_i       = mdl_res;

    always @(posedge clk) begin
        if (rst) begin
            mq_data.delete();
            mq_due.delete();
            cyc     <= 0;
            mdl_vld <= 1'b0;
            mdl_res <= '0;
        end else begin
            if (mdl_vld && mul_res_ready_o && (mq_data.size() > 0)) begin
                void'(mq_data.pop_front());
                void'(mq_due.pop_front());
            end
            if (mul_op_valid_o && mul_op_ready_i) begin
                mq_data.push_back((mul_op2_o == MC) ? mul_op1_o : '0);
                mq_due.push_back(cyc + 3);
            end
            cyc <= cyc + 1;
            if ((mq_due.size() > 0) && (mq_due[0] <= cyc + 1)) begin
                mdl_vld <= 1'b1;
                mdl_res <= mq_data[0];
            end else begin
                mdl_vld <= 1'b0;
                mdl_res <= '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance to the next negedge; retire requests accepted at the edge just passed.
    task automatic step();
        @(negedge clk);
        if (!hold) req_valid_i &= ~last_rdy;
        last_rdy = '0;
    endtask

    task automatic sample();
        #1;
        last_rdy = req_ready_o;
        if (req_ready_o != '0) gnt_q.push_back(req_ready_o);
        if ((res_valid_o & res_ready_i) != '0) begin
            rb_q.push_back(res_valid_o);
            rv_q.push_back(res_o);
        end
    endtask

    task automatic clr();
        gnt_q.delete();
        rb_q.delete();
        rv_q.delete();
    endtask

    task automatic set_op(input int k, input logic [DW-1:0] a);
        req_op1_i[k*DW +: DW] = a;
        req_op2_i[k*DW +: DW] = MC;
    endtask

    task automatic set_default_ops();
        for (int k = 0; k < int'(NR); k++) set_op(k, DW'(k + 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        req_valid_i    = '0;
        res_ready_i    = '0;
        mul_op_ready_i = 1'b0;
        force_orphan   = 1'b0;
        hold           = 1'b0;
        last_rdy       = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr();
    endtask

    task automatic wait_res(input string name, input int n, input int budget);
        int t;
        t = 0;
        while ((rb_q.size() < n) && (t < budget)) begin
            step();
            sample();
            t++;
        end
        chk({name, "_count"}, DW'(rb_q.size()), DW'(n));
    endtask

    function automatic logic [NR-1:0] rb_at(input int i);
        return (i < rb_q.size()) ? rb_q[i] : '0;
    endfunction

    function automatic logic [DW-1:0] rv_at(input int i);
        return (i < rv_q.size()) ? rv_q[i] : '0;
    endfunction

    function automatic logic [NR-1:0] gnt_at(input int i);
        return (i < gnt_q.size()) ? gnt_q[i] : '0;
    endfunction

    typedef struct {
        logic [NR-1:0] req;
        logic          exp_valid;
        logic [DW-1:0] exp_op1;
    } vec_t;

    vec_t tbl [10];

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step();
            req_valid_i = tbl[i].req;
            sample();
            chk($sformatf("tbl%0d_valid", i), DW'(mul_op_valid_o), DW'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_op1", i), mul_op1_o, tbl[i].exp_op1);
            chk($sformatf("tbl%0d_ready", i), DW'(req_ready_o), '0);
        end
        step();
        req_valid_i = '0;
    endtask

    initial begin
        // op1 of requester k is k+1, multiplier stalled: pure grant decode.
        // Rows 0-5 with rr pointer 0, rows 6-9 with pointer 3.
        tbl[0] = '{req: 4'b0000, exp_valid: 1'b0, exp_op1: DW'(0)};
        tbl[1] = '{req: 4'b0001, exp_valid: 1'b1, exp_op1: DW'(1)};
        tbl[2] = '{req: 4'b1000, exp_valid: 1'b1, exp_op1: DW'(4)};
        tbl[3] = '{req: 4'b0110, exp_valid: 1'b1, exp_op1: DW'(2)};
        tbl[4] = '{req: 4'b1010, exp_valid: 1'b1, exp_op1: DW'(2)};
        tbl[5] = '{req: 4'b1111, exp_valid: 1'b1, exp_op1: DW'(1)};
        tbl[6] = '{req: 4'b1111, exp_valid: 1'b1, exp_op1: DW'(4)};
        tbl[7] = '{req: 4'b0111, exp_valid: 1'b1, exp_op1: DW'(1)};
        tbl[8] = '{req: 4'b0100, exp_valid: 1'b1, exp_op1: DW'(3)};
        tbl[9] = '{req: 4'b0000, exp_valid: 1'b0, exp_op1: DW'(0)};

        // Reset state
        do_reset();
        sample();
        chk("rst_busy", DW'(busy_o), '0);
        chk("rst_err", DW'(err_orphan_o), '0);
        chk("rst_count", DW'(op_count_o), '0);
        chk("rst_res_valid", DW'(res_valid_o), '0);
        chk("rst_op_valid", DW'(mul_op_valid_o), '0);
        chk("rst_res_ready", DW'(mul_res_ready_o), '0);

        set_default_ops();
        run_tbl(0, 5);

        // Single request from 2 with op2 = R mod p
        res_ready_i    = '1;
        mul_op_ready_i = 1'b1;
        set_op(2, DW'(5));
        req_valid_i = 4'b0100;
        sample();
        chk("t1_ready", DW'(req_ready_o), DW'(4'b0100));
        chk("t1_op1", mul_op1_o, DW'(5));
        chk("t1_op2", mul_op2_o, MC);
        step();
        sample();
        chk("t1_busy", DW'(busy_o), DW'(1));
        chk("t1_opcount", DW'(op_count_o), DW'(1));
        wait_res("t1_res", 1, 10);
        chk("t1_res_bit", DW'(rb_at(0)), DW'(4'b0100));
        chk("t1_res_val", rv_at(0), DW'(5));
        step();
        sample();
        chk("t1_busy_after", DW'(busy_o), '0);

        // Pointer now 3
        mul_op_ready_i = 1'b0;
        set_default_ops();
        run_tbl(6, 9);

        // All four requesting continuously
        do_reset();
        set_default_ops();
        hold           = 1'b1;
        res_ready_i    = '1;
        mul_op_ready_i = 1'b1;
        req_valid_i    = '1;
        for (int t = 0; (t < 200) && (gnt_q.size() < 8); t++) begin
            sample();
            if (gnt_q.size() < 8) step();
        end
        step();
        hold        = 1'b0;
        req_valid_i = '0;
        sample();
        chk("t2_grants", DW'(gnt_q.size()), DW'(8));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_grant%0d", i), DW'(gnt_at(i)), DW'(4'b0001 << (i % 4)));
        end
        wait_res("t2_res", 8, 100);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_res_bit%0d", i), DW'(rb_at(i)), DW'(4'b0001 << (i % 4)));
            chk($sformatf("t2_res_val%0d", i), rv_at(i), DW'((i % 4) + 1));
        end
        chk("t2_opcount", DW'(op_count_o), DW'(8));

        // Requester 1 back-pressures its result for 10 cycles
        do_reset();
        set_op(0, DW'(9));
        set_op(1, DW'(7));
        set_op(2, DW'(11));
        res_ready_i    = 4'b1101;
        mul_op_ready_i = 1'b1;
        step();
        req_valid_i = 4'b0010;
        sample();
        chk("t3_grant1", DW'(req_ready_o), DW'(4'b0010));
        for (int t = 0; (t < 20) && !mul_res_valid_i; t++) begin
            step();
            sample();
        end
        chk("t3_arrived", DW'(mul_res_valid_i), DW'(1));
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) req_valid_i |= 4'b0001;
            if (i == 3) req_valid_i |= 4'b0100;
            sample();
            chk($sformatf("t3_hold_vld%0d", i), DW'(res_valid_o), DW'(4'b0010));
            chk($sformatf("t3_hold_rdy%0d", i), DW'(mul_res_ready_o), '0);
            if (i == 2) chk("t3_other_grant", DW'(req_ready_o), DW'(4'b0001));
            if (i == 3) chk("t3_full_valid", DW'(mul_op_valid_o), '0);
            if (i == 3) chk("t3_full_ready", DW'(req_ready_o), '0);
        end
        step();
        res_ready_i = '1;
        sample();
        chk("t3_release_rdy", DW'(mul_res_ready_o), DW'(1));
        chk("t3_push_while_full", DW'(req_ready_o), '0);
        wait_res("t3_res", 3, 40);
        chk("t3_res0_bit", DW'(rb_at(0)), DW'(4'b0010));
        chk("t3_res0_val", rv_at(0), DW'(7));
        chk("t3_res1_bit", DW'(rb_at(1)), DW'(4'b0001));
        chk("t3_res1_val", rv_at(1), DW'(9));
        chk("t3_res2_bit", DW'(rb_at(2)), DW'(4'b0100));
        chk("t3_res2_val", rv_at(2), DW'(11));

        // Multiplier op_ready low for 5 cycles with requesters 0 and 3 waiting
        do_reset();
        set_op(0, DW'(16));
        set_op(3, DW'(64));
        res_ready_i = '1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) req_valid_i = 4'b1001;
            sample();
            chk($sformatf("t4_stall_vld%0d", i), DW'(mul_op_valid_o), DW'(1));
            chk($sformatf("t4_stall_op1_%0d", i), mul_op1_o, DW'(16));
            chk($sformatf("t4_stall_rdy%0d", i), DW'(req_ready_o), '0);
        end
        step();
        mul_op_ready_i = 1'b1;
        sample();
        chk("t4_grant0", DW'(req_ready_o), DW'(4'b0001));
        step();
        sample();
        chk("t4_grant3", DW'(req_ready_o), DW'(4'b1000));
        chk("t4_op1_3", mul_op1_o, DW'(64));
        step();
        sample();
        wait_res("t4_res", 2, 30);
        chk("t4_res0_bit", DW'(rb_at(0)), DW'(4'b0001));
        chk("t4_res0_val", rv_at(0), DW'(16));
        chk("t4_res1_bit", DW'(rb_at(1)), DW'(4'b1000));
        chk("t4_res1_val", rv_at(1), DW'(64));

        // Orphan result with the tag FIFO empty
        step();
        sample();
        chk("t5_idle", DW'(busy_o), '0);
        step();
        force_orphan = 1'b1;
        sample();
        chk("t5_drain_rdy", DW'(mul_res_ready_o), DW'(1));
        chk("t5_no_res", DW'(res_valid_o), '0);
        step();
        force_orphan = 1'b0;
        sample();
        chk("t5_err_set", DW'(err_orphan_o), DW'(1));
        for (int i = 0; i < 3; i++) step();
        sample();
        chk("t5_err_sticky", DW'(err_orphan_o), DW'(1));
        chk("t5_no_res2", DW'(res_valid_o), '0);

        // Reset while an op is in flight
        clr();
        set_op(2, DW'(21));
        mul_op_ready_i = 1'b1;
        step();
        req_valid_i = 4'b0100;
        sample();
        chk("t6_grant", DW'(req_ready_o), DW'(4'b0100));
        step();
        sample();
        chk("t6_busy", DW'(busy_o), DW'(1));
        step();
        rst = 1'b1;
        sample();
        chk("t6_rst_busy", DW'(busy_o), '0);
        chk("t6_rst_res_vld", DW'(res_valid_o), '0);
        chk("t6_rst_op_vld", DW'(mul_op_valid_o), '0);
        chk("t6_rst_res_rdy", DW'(mul_res_ready_o), '0);
        step();
        sample();
        chk("t6_rst_count", DW'(op_count_o), '0);
        chk("t6_rst_err", DW'(err_orphan_o), '0);
        step();
        rst = 1'b0;
        sample();
        chk("t6_post_busy", DW'(busy_o), '0);
        for (int i = 0; i < 6; i++) begin
            step();
            sample();
        end
        chk("t6_dropped", DW'(rb_q.size()), '0);
        set_op(1, DW'(31));
        set_op(3, DW'(33));
        step();
        req_valid_i = 4'b1010;
        sample();
        chk("t6_ptr0_grant", DW'(req_ready_o), DW'(4'b0010));
        step();
        sample();
        chk("t6_next_grant", DW'(req_ready_o), DW'(4'b1000));
        step();
        sample();
        wait_res("t6_res", 2, 30);
        chk("t6_res0_bit", DW'(rb_at(0)), DW'(4'b0010));
        chk("t6_res0_val", rv_at(0), DW'(31));
        chk("t6_res1_bit", DW'(rb_at(1)), DW'(4'b1000));
        chk("t6_res1_val", rv_at(1), DW'(33));
        chk("t6_opcount", DW'(op_count_o), DW'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
